// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, buffered entry, instruction size.
package ifetch_pkg;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_HALT = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch bus: instruction memory request/response plus the decode-side valid/ready handshake.
interface instr_fetch_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr_address;
  logic [31:0] instr_data;

  modport master (
    output mem_req_valid, mem_req_addr, out_valid, instr_address, instr_data,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, out_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, out_valid, instr_address, instr_data,
    output mem_req_ready, mem_resp_valid, mem_resp_data, out_ready
  );
endinterface

// File: rtl/ifetch_fifo.sv
// Output buffer for fetched {addr, data} entries; flush wins over push/pop, push+pop allowed when full.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, pop_ok, push_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = pop && (count_q != '0);
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_q] = wdata;
        wr_d        = wr_q + AW'(1);
      end
      if (pop_ok) rd_d = rd_q + AW'(1);
      if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
      else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Request gating by free slots makes an overflowing push impossible.
  always_ff @(posedge clk) begin
    if (reset) assert (!(push && full && !pop));
  end

  assign head  = mem_q[rd_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, single-outstanding memory request FSM, redirect/flush, 2/4-entry output buffer.
// Optional IFETCH_ALIGN_CHECK_EN: misaligned redirect raises sticky fetch_fault and halts fetch.
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic           clk,
  input  logic           reset,
  instr_fetch_if.master  bus,
  input  logic           redirect_valid,
  input  logic [31:0]    redirect_pc,
  output logic           fetch_fault
);

  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int CW1 = CW + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic          fault_q, fault_d;

  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head;
  fetch_entry_t  push_entry;
  logic          outstanding, credit_ok, req_valid, accept;
  logic          redir, misalign, in_flight, halted;
  logic          push, pop, flush;
  logic [31:0]   redir_pc;

  assign outstanding = (state_q == S_WAIT);
  assign credit_ok   = ({1'b0, fifo_count} + CW1'(outstanding)) < CW1'(FIFO_DEPTH);
  assign req_valid   = (state_q == S_REQ) && credit_ok && reset;
  assign accept      = req_valid && bus.mem_req_ready;
  assign halted      = (state_q == S_HALT);

`ifdef IFETCH_ALIGN_CHECK_EN
  assign redir_pc = redirect_pc;
  assign misalign = (redirect_pc[1:0] != 2'b00);
`else
  assign redir_pc = redirect_pc & ~32'h3;
  assign misalign = 1'b0;
`endif

  // A halted fetch unit ignores redirects until reset.
  assign redir     = redirect_valid && !halted;
  assign in_flight = accept ||
                     (((state_q == S_WAIT) || (state_q == S_DROP)) && !bus.mem_resp_valid);
  assign push      = (state_q == S_WAIT) && bus.mem_resp_valid && !redir;
  assign pop       = bus.out_ready && (fifo_count != '0);
  assign flush     = redir || halted;
  assign push_entry = '{addr: req_addr_q, data: bus.mem_resp_data};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    fault_d    = fault_q;
    case (state_q)
      S_REQ: if (accept) begin
        pc_d       = pc_q + INSTR_BYTES;
        req_addr_d = pc_q;
        state_d    = S_WAIT;
      end
      S_WAIT:  if (bus.mem_resp_valid) state_d = S_REQ;
      S_DROP:  if (bus.mem_resp_valid) state_d = S_REQ;
      default: ;
    endcase
    if (redir) begin
      if (misalign) begin
        fault_d = 1'b1;
        state_d = S_HALT;
      end else begin
        pc_d    = redir_pc;
        state_d = in_flight ? S_DROP : S_REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      fault_q    <= fault_d;
    end
  end

  ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (push_entry),
    .head  (fifo_head),
    .count (fifo_count)
  );

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = pc_q;
  assign bus.out_valid     = (fifo_count != '0);
  assign bus.instr_address = fifo_head.addr;
  assign bus.instr_data    = fifo_head.data;
  assign fetch_fault       = fault_q;

endmodule
